bram_wb_banked: RTL and testbench
=================================

Name: bram_wb_banked

Overview:
Parametrised successor to the single-bank wishbone BRAM. It provides NUM_BANKS independent dual-port BRAM banks. The wishbone slave port decodes and accesses all banks, with byte-select writes, a configurable read latency and an error response. Each bank has its own fabric port. Everything runs on one clock, and the block sits on the wishbone bus as a memory-mapped buffer shared with fabric logic.

Parameters:
DEV_BASE_ADDR, 0, first word address decoded by this device
NUM_BANKS, 4, number of BRAM banks; power of two, 1..16
BUS_DATA_WIDTH, 32, wishbone and fabric data width; multiple of 8
BUS_ADDR_WIDTH, 16, wishbone word-address width
RAM_ADDR_WIDTH, 8, per-bank address width; depth is 2**RAM_ADDR_WIDTH
READ_LATENCY, 1, BRAM read pipeline depth, 1..4, applies to both ports

Ports:
wbs_clk_i  in  1  sole clock, used by fabric and wishbone sides
wbs_rst_i  in  1  synchronous, active-high reset
fabric_we  in  NUM_BANKS  per-bank fabric write enable
fabric_addr  in  NUM_BANKS*RAM_ADDR_WIDTH  per-bank address, bank k at slice k
fabric_data_in  in  NUM_BANKS*BUS_DATA_WIDTH  per-bank write data
fabric_data_out  out  NUM_BANKS*BUS_DATA_WIDTH  per-bank read data, valid READ_LATENCY cycles after the address
wbs_cyc_i  in  1  bus cycle
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  write when 1
wbs_sel_i  in  BUS_DATA_WIDTH/8  byte selects
wbs_adr_i  in  BUS_ADDR_WIDTH  word address
wbs_dat_i  in  BUS_DATA_WIDTH  write data
wbs_dat_o  out  BUS_DATA_WIDTH  read data, registered
wbs_ack_o  out  1  single-cycle acknowledge
wbs_err_o  out  1  single-cycle error: address outside the window
collision_o  out  1  one-cycle pulse: wishbone write dropped because fabric wrote the same bank and address in the same cycle

Behaviour:
- Clock and reset: one clock (wbs_clk_i); reset wbs_rst_i is synchronous and active-high.
- Reset values: wbs_dat_o=0, wbs_ack_o=0, wbs_err_o=0, collision_o=0, FSM=IDLE, read pipeline flushed. RAM contents are not cleared.
- Address decode:
  - off = wbs_adr_i - DEV_BASE_ADDR.
  - Hit when DEV_BASE_ADDR <= wbs_adr_i < DEV_BASE_ADDR + NUM_BANKS*2**RAM_ADDR_WIDTH.
  - bank = off[RAM_ADDR_WIDTH +: log2(NUM_BANKS)]; word = off[RAM_ADDR_WIDTH-1:0].
- Request acceptance: a request is accepted in IDLE when cyc&stb=1.
- FSM IDLE -> ACK, write hit:
  - The write is issued to the bank in the acceptance cycle.
  - Only bytes with sel=1 are updated.
  - ack rises the next cycle.
- FSM IDLE -> RD_WAIT, read hit:
  - A down-counter is loaded with READ_LATENCY-1.
  - When the counter reaches 0, the bank output is captured into wbs_dat_o and the FSM goes to ACK.
  - ack is high exactly READ_LATENCY+1 cycles after acceptance.
- FSM IDLE -> ERR, miss: err rises the next cycle; wbs_dat_o=0; no RAM access.
- ACK/ERR -> IDLE after one cycle. ack/err are one-cycle pulses, never both high.
- Back-to-back: a new request is accepted only in IDLE. With stb held, the next access is accepted the cycle after ack.
- Abort: if cyc or stb drops during RD_WAIT, return to IDLE with no ack and wbs_dat_o unchanged.
- Collision: a fabric write and a wishbone write to the same bank and word in the same cycle.
  - The fabric write wins and the wishbone write is suppressed.
  - collision_o pulses in that cycle, and ack is still returned.
- Reads versus writes: reads return old data on a simultaneous write to the same address, on either port.
- Reset mid-operation: the FSM returns to IDLE and no ack is issued for the pending access.
- Fabric read: fabric_data_out[k] is registered with READ_LATENCY stages.

Decomposition:
- Package bram_wb_pkg: clog2 function, FSM state encoding (IDLE, RD_WAIT, ACK, ERR), and the byte-lane count macro BUS_DATA_WIDTH/8.
- Sub-module bram_sync_dp_be: one dual-port bank with per-byte write enable on port B, a READ_LATENCY output pipeline on both ports, and collision detection. It is instantiated NUM_BANKS times in a generate loop.
- The top level holds the decode, the FSM and the read mux.

Test Plan:
- Reset asserted for 2 cycles mid read -> ack never asserts; all outputs 0 next cycle; a subsequent read completes normally.
- WB write 0xDEADBEEF sel=4'hF to bank 2 word 5 (adr=0x205), then read 0x205 with READ_LATENCY=3 -> ack 1 cycle after write acceptance; read ack 4 cycles after acceptance with wbs_dat_o=0xDEADBEEF; fabric_addr[2]=5 shows the same value 3 cycles later.
- Write 0x11223344 sel=4'hF, then 0xAABBCCDD sel=4'b0101 to the same word -> read returns 0x11BB33DD.
- Read at adr=0x400 with NUM_BANKS=4, RAM_ADDR_WIDTH=8 -> wbs_err_o pulses 1 cycle, ack stays 0, dat_o=0.
- Fabric write 0x1 and WB write 0x2 to bank 0 word 7 in the same cycle -> collision_o=1, ack=1, readback 0x1.
- Read issued, stb dropped after 1 cycle with READ_LATENCY=4 -> no ack, FSM back in IDLE; the next write is accepted.

Source files
------------

// File: rtl/bram_wb_pkg.sv
// rtl/bram_wb_pkg.sv - shared types and helpers for the banked wishbone BRAM
package bram_wb_pkg;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Number of byte lanes in a data word
  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

  // Wishbone slave FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2,
    ST_ERR     = 2'd3
  } wb_state_t;

endpackage

// File: rtl/bram_wb_banked_if.sv
// rtl/bram_wb_banked_if.sv - wishbone slave bus bundle with master/slave views
interface bram_wb_banked_if
  import bram_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                            wbs_cyc_i;
  logic                            wbs_stb_i;
  logic                            wbs_we_i;
  logic [byte_lanes(DATA_W)-1:0]   wbs_sel_i;
  logic [ADDR_W-1:0]               wbs_adr_i;
  logic [DATA_W-1:0]               wbs_dat_i;
  logic [DATA_W-1:0]               wbs_dat_o;
  logic                            wbs_ack_o;
  logic                            wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/bram_sync_dp_be.sv
// rtl/bram_sync_dp_be.sv - one dual-port bank, byte-enabled port B, pipelined reads
module bram_sync_dp_be
  import bram_wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
)(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_a_we,
  input  logic [ADDR_W-1:0]             i_a_addr,
  input  logic [DATA_W-1:0]             i_a_din,
  output logic [DATA_W-1:0]             o_a_dout,
  input  logic                          i_b_we,
  input  logic [byte_lanes(DATA_W)-1:0] i_b_be,
  input  logic [ADDR_W-1:0]             i_b_addr,
  input  logic [DATA_W-1:0]             i_b_din,
  output logic [DATA_W-1:0]             o_b_dout,
  output logic                          o_collision
);
  localparam int LP_NBYTE = byte_lanes(DATA_W);
  localparam int LP_DEPTH = 1 << ADDR_W;

  logic              w_b_wr;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // Same-cycle, same-word writes from both ports: fabric (port A) wins
  assign o_collision = i_a_we && i_b_we && (i_a_addr == i_b_addr);
  assign w_b_wr      = i_b_we && !o_collision;

  for (genvar gl = 0; gl < LP_NBYTE; gl++) begin : g_lane
    logic [7:0] r_mem [0:LP_DEPTH-1];
    logic [7:0] r_q_a;
    logic [7:0] r_q_b;

    // Byte-lane storage; reads see the pre-write contents (read-first)
    always_ff @(posedge i_clk) begin
      if (i_a_we)
        r_mem[i_a_addr] <= i_a_din[gl*8 +: 8];
      if (w_b_wr && i_b_be[gl])
        r_mem[i_b_addr] <= i_b_din[gl*8 +: 8];
      if (i_rst) begin
        r_q_a <= '0;
        r_q_b <= '0;
      end else begin
        r_q_a <= r_mem[i_a_addr];
        r_q_b <= r_mem[i_b_addr];
      end
    end

    assign w_rd_a[gl*8 +: 8] = r_q_a;
    assign w_rd_b[gl*8 +: 8] = r_q_b;
  end

  if (LATENCY > 1) begin : g_pipe
    logic [DATA_W-1:0] r_pa [LATENCY-1];
    logic [DATA_W-1:0] r_pb [LATENCY-1];

    // Extra output stages behind the array read register
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int i = 0; i < LATENCY-1; i++) begin
          r_pa[i] <= '0;
          r_pb[i] <= '0;
        end
      end else begin
        r_pa[0] <= w_rd_a;
        r_pb[0] <= w_rd_b;
        for (int i = 1; i < LATENCY-1; i++) begin
          r_pa[i] <= r_pa[i-1];
          r_pb[i] <= r_pb[i-1];
        end
      end
    end

    assign o_a_dout = r_pa[LATENCY-2];
    assign o_b_dout = r_pb[LATENCY-2];
  end else begin : g_nopipe
    assign o_a_dout = w_rd_a;
    assign o_b_dout = w_rd_b;
  end
endmodule

// File: rtl/bram_wb_banked.sv
// rtl/bram_wb_banked.sv - banked BRAM shared between wishbone slave and fabric ports
module bram_wb_banked
  import bram_wb_pkg::*;
#(
  parameter int unsigned DEV_BASE_ADDR  = 0,
  parameter int          NUM_BANKS      = 4,
  parameter int          BUS_DATA_WIDTH = 32,
  parameter int          BUS_ADDR_WIDTH = 16,
  parameter int          RAM_ADDR_WIDTH = 8,
  parameter int          READ_LATENCY   = 1
)(
  input  logic                                wbs_clk_i,
  input  logic                                wbs_rst_i,
  input  logic [NUM_BANKS-1:0]                fabric_we,
  input  logic [NUM_BANKS*RAM_ADDR_WIDTH-1:0] fabric_addr,
  input  logic [NUM_BANKS*BUS_DATA_WIDTH-1:0] fabric_data_in,
  output logic [NUM_BANKS*BUS_DATA_WIDTH-1:0] fabric_data_out,
  output logic                                collision_o,
  bram_wb_banked_if.slave                     wb
);
  localparam int LP_BANK_BITS = clog2(NUM_BANKS);
  localparam int LP_BW        = (LP_BANK_BITS > 0) ? LP_BANK_BITS : 1;
  localparam logic [BUS_ADDR_WIDTH:0] LP_BASE =
    (BUS_ADDR_WIDTH+1)'(DEV_BASE_ADDR);
  localparam logic [BUS_ADDR_WIDTH:0] LP_SPAN =
    (BUS_ADDR_WIDTH+1)'(NUM_BANKS * (1 << RAM_ADDR_WIDTH));

  wb_state_t                 r_state;
  wb_state_t                 w_state_nxt;
  logic [1:0]                r_cnt;
  logic [1:0]                w_cnt_nxt;
  logic [LP_BW-1:0]          r_bank;
  logic [LP_BW-1:0]          w_bank_nxt;
  logic [BUS_DATA_WIDTH-1:0] r_dat_o;
  logic [BUS_DATA_WIDTH-1:0] w_dat_nxt;
  logic                      w_wr_go;

  logic                      w_req;
  logic                      w_hit;
  logic [BUS_ADDR_WIDTH-1:0] w_off;
  logic [LP_BW-1:0]          w_bank;
  logic [RAM_ADDR_WIDTH-1:0] w_word;
  logic [BUS_DATA_WIDTH-1:0] w_b_dout [NUM_BANKS];
  logic [NUM_BANKS-1:0]      w_coll;

  assign w_req  = wb.wbs_cyc_i && wb.wbs_stb_i;
  assign w_off  = wb.wbs_adr_i - LP_BASE[BUS_ADDR_WIDTH-1:0];
  assign w_hit  = ({1'b0, wb.wbs_adr_i} >= LP_BASE) && ({1'b0, w_off} < LP_SPAN);
  assign w_word = w_off[RAM_ADDR_WIDTH-1:0];

  if (NUM_BANKS > 1) begin : g_bank_sel
    assign w_bank = w_off[RAM_ADDR_WIDTH +: LP_BW];
  end else begin : g_bank_one
    assign w_bank = '0;
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    bram_sync_dp_be #(
      .DATA_W  (BUS_DATA_WIDTH),
      .ADDR_W  (RAM_ADDR_WIDTH),
      .LATENCY (READ_LATENCY)
    ) u_bank (
      .i_clk       (wbs_clk_i),
      .i_rst       (wbs_rst_i),
      .i_a_we      (fabric_we[gi]),
      .i_a_addr    (fabric_addr[gi*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH]),
      .i_a_din     (fabric_data_in[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]),
      .o_a_dout    (fabric_data_out[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]),
      .i_b_we      (w_wr_go && (w_bank == LP_BW'(gi))),
      .i_b_be      (wb.wbs_sel_i),
      .i_b_addr    (w_word),
      .i_b_din     (wb.wbs_dat_i),
      .o_b_dout    (w_b_dout[gi]),
      .o_collision (w_coll[gi])
    );
  end

  assign collision_o  = |w_coll;
  assign wb.wbs_dat_o = r_dat_o;
  assign wb.wbs_ack_o = (r_state == ST_ACK);
  assign wb.wbs_err_o = (r_state == ST_ERR);

  // Next-state, latency counter, bank latch, read capture and write strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bank_nxt  = r_bank;
    w_dat_nxt   = r_dat_o;
    w_wr_go     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (!w_hit) begin
            w_state_nxt = ST_ERR;
            w_dat_nxt   = '0;
          end else if (wb.wbs_we_i) begin
            w_wr_go     = !wbs_rst_i;
            w_state_nxt = ST_ACK;
          end else begin
            w_state_nxt = ST_RD_WAIT;
            w_cnt_nxt   = 2'(READ_LATENCY - 1);
            w_bank_nxt  = w_bank;
          end
        end
      end
      ST_RD_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 2'd0) begin
          w_dat_nxt   = w_b_dout[r_bank];
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and bus-side registers
  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bank  <= '0;
      r_dat_o <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bank  <= w_bank_nxt;
      r_dat_o <= w_dat_nxt;
    end
  end
endmodule

// File: tb/tb_bram_wb_banked.sv
// tb/tb_bram_wb_banked.sv - directed scoreboard bench for bram_wb_banked
module tb_bram_wb_banked;
  localparam int NB  = 4;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int RAW = 8;
  localparam int LAT = 3;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NB-1:0]       fabric_we;
  logic [NB*RAW-1:0]   fabric_addr;
  logic [NB*DW-1:0]    fabric_data_in;
  logic [NB*DW-1:0]    fabric_data_out;
  logic                collision_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  bram_wb_banked_if #(.DATA_W(DW), .ADDR_W(AW)) wb ();

  bram_wb_banked #(
    .DEV_BASE_ADDR  (0),
    .NUM_BANKS      (NB),
    .BUS_DATA_WIDTH (DW),
    .BUS_ADDR_WIDTH (AW),
    .RAM_ADDR_WIDTH (RAW),
    .READ_LATENCY   (LAT)
  ) dut (
    .wbs_clk_i       (clk),
    .wbs_rst_i       (rst),
    .fabric_we       (fabric_we),
    .fabric_addr     (fabric_addr),
    .fabric_data_in  (fabric_data_in),
    .fabric_data_out (fabric_data_out),
    .collision_o     (collision_o),
    .wb              (wb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One wishbone access; optional same-cycle fabric write to the same bank/word
  task automatic wb_req(input string tag, input logic we, input logic [15:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        input logic fab, input logic [31:0] fdat,
                        input logic exp_err, input logic [31:0] exp_dat, input int exp_lat);
    exp_t e;
    int   n;
    logic got;
    int   bk;
    e.err = exp_err;
    e.dat = exp_dat;
    e.lat = exp_lat;
    sb.push_back(e);
    bk = int'(adr[9:8]);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_sel_i = sel;
    wb.wbs_dat_i = dat;
    if (fab) begin
      fabric_we[bk]                 = 1'b1;
      fabric_addr[bk*RAW +: RAW]    = adr[7:0];
      fabric_data_in[bk*DW +: DW]   = fdat;
    end
    #1;
    check({tag, "_coll"}, {31'b0, collision_o}, {31'b0, fab});
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      fabric_we = '0;
      if (wb.wbs_ack_o || wb.wbs_err_o) got = 1'b1;
    end
    e = sb.pop_front();
    check({tag, "_done"}, {31'b0, got}, 32'd1);
    if (got) begin
      check({tag, "_lat"}, n, e.lat);
      check({tag, "_ack"}, {31'b0, wb.wbs_ack_o}, {31'b0, !e.err});
      check({tag, "_err"}, {31'b0, wb.wbs_err_o}, {31'b0, e.err});
      if (!we || e.err) check({tag, "_dat"}, wb.wbs_dat_o, e.dat);
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic any_ack;
    rst            = 1'b1;
    fabric_we      = '0;
    fabric_addr    = '0;
    fabric_data_in = '0;
    wb.wbs_cyc_i   = 1'b0;
    wb.wbs_stb_i   = 1'b0;
    wb.wbs_we_i    = 1'b0;
    wb.wbs_sel_i   = '0;
    wb.wbs_adr_i   = '0;
    wb.wbs_dat_i   = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_ack",  {31'b0, wb.wbs_ack_o}, 32'd0);
    check("rst_err",  {31'b0, wb.wbs_err_o}, 32'd0);
    check("rst_dat",  wb.wbs_dat_o, 32'd0);
    check("rst_coll", {31'b0, collision_o}, 32'd0);
    tick();

    // Basic write/read, read latency LAT+1 to ack
    wb_req("w206", 1'b1, 16'h0206, 4'hF, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, 32'h0, 1);
    wb_req("w205", 1'b1, 16'h0205, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0, 1);
    wb_req("r205", 1'b0, 16'h0205, 4'hF, 32'h0,        1'b0, 32'h0, 1'b0, 32'hDEADBEEF, LAT+1);

    // Fabric port of bank 2 sees the value exactly LAT cycles after the address
    fabric_addr[2*RAW +: RAW] = 8'd6;
    repeat (LAT) tick();
    fabric_addr[2*RAW +: RAW] = 8'd5;
    tick();
    check("fab_lat1", fabric_data_out[2*DW +: DW], 32'h0BADF00D);
    tick();
    check("fab_lat2", fabric_data_out[2*DW +: DW], 32'h0BADF00D);
    tick();
    check("fab_lat3", fabric_data_out[2*DW +: DW], 32'hDEADBEEF);

    // Byte-select merge
    wb_req("w010a", 1'b1, 16'h0010, 4'hF,    32'h11223344, 1'b0, 32'h0, 1'b0, 32'h0, 1);
    wb_req("w010b", 1'b1, 16'h0010, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0, 1'b0, 32'h0, 1);
    wb_req("r010",  1'b0, 16'h0010, 4'hF,    32'h0,        1'b0, 32'h0, 1'b0, 32'h11BB33DD, LAT+1);

    // Last word inside the window, then first words outside it
    wb_req("w3ff", 1'b1, 16'h03FF, 4'hF, 32'hCAFE0001, 1'b0, 32'h0, 1'b0, 32'h0, 1);
    wb_req("r3ff", 1'b0, 16'h03FF, 4'hF, 32'h0,        1'b0, 32'h0, 1'b0, 32'hCAFE0001, LAT+1);
    wb_req("r400", 1'b0, 16'h0400, 4'hF, 32'h0,        1'b0, 32'h0, 1'b1, 32'h0, 1);
    wb_req("wfff", 1'b1, 16'hFFFF, 4'hF, 32'h12345678, 1'b0, 32'h0, 1'b1, 32'h0, 1);

    // Collision: fabric write wins, bus still acked
    wb_req("wcol", 1'b1, 16'h0007, 4'hF, 32'h00000002, 1'b1, 32'h00000001, 1'b0, 32'h0, 1);
    wb_req("rcol", 1'b0, 16'h0007, 4'hF, 32'h0,        1'b0, 32'h0, 1'b0, 32'h00000001, LAT+1);

    // Abort a read by dropping stb in RD_WAIT
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = 16'h0205;
    tick();
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    any_ack = 1'b0;
    repeat (6) begin
      tick();
      any_ack = any_ack | wb.wbs_ack_o | wb.wbs_err_o;
    end
    check("abort_noack", {31'b0, any_ack}, 32'd0);
    check("abort_dat",   wb.wbs_dat_o, 32'h00000001);
    wb_req("w030", 1'b1, 16'h0030, 4'hF, 32'h00000055, 1'b0, 32'h0, 1'b0, 32'h0, 1);

    // Reset in the middle of a read
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = 16'h0010;
    tick();
    rst          = 1'b1;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    any_ack = 1'b0;
    repeat (2) begin
      tick();
      any_ack = any_ack | wb.wbs_ack_o;
    end
    rst = 1'b0;
    check("mrst_dat",  wb.wbs_dat_o, 32'd0);
    check("mrst_err",  {31'b0, wb.wbs_err_o}, 32'd0);
    check("mrst_coll", {31'b0, collision_o}, 32'd0);
    repeat (5) begin
      tick();
      any_ack = any_ack | wb.wbs_ack_o;
    end
    check("mrst_noack", {31'b0, any_ack}, 32'd0);
    wb_req("r010b", 1'b0, 16'h0010, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 32'h11BB33DD, LAT+1);
    wb_req("r030",  1'b0, 16'h0030, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 32'h00000055, LAT+1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
